// File: rtl/or1200_keccak_alu_pkg.sv
// Shared constants and types for the OR1200 ALU with Keccak coprocessor control.
package or1200_keccak_alu_pkg;

    localparam int unsigned ALU_WIDTH    = 32;
    localparam int unsigned ALUOP_W      = 5;
    localparam int unsigned ALUOP2_W     = 4;
    localparam int unsigned COMPOP_W     = 4;
    localparam int unsigned CUST5_OP_W   = 5;
    localparam int unsigned CUST5_LIMM_W = 6;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 5'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDC  = 5'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 5'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_AND   = 5'd3;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 5'd4;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR   = 5'd5;
    localparam logic [ALUOP_W-1:0] ALUOP_MUL   = 5'd6;
    localparam logic [ALUOP_W-1:0] ALUOP_SHROT = 5'd8;
    localparam logic [ALUOP_W-1:0] ALUOP_DIV   = 5'd9;
    localparam logic [ALUOP_W-1:0] ALUOP_DIVU  = 5'd10;
    localparam logic [ALUOP_W-1:0] ALUOP_MULU  = 5'd11;
    localparam logic [ALUOP_W-1:0] ALUOP_CUST5 = 5'd12;
    localparam logic [ALUOP_W-1:0] ALUOP_CMOV  = 5'd14;
    localparam logic [ALUOP_W-1:0] ALUOP_FFL1  = 5'd15;
    localparam logic [ALUOP_W-1:0] ALUOP_MOVHI = 5'd16;
    localparam logic [ALUOP_W-1:0] ALUOP_COMP  = 5'd17;

    localparam logic [ALUOP2_W-1:0] SHROTOP_SLL = 4'd0;
    localparam logic [ALUOP2_W-1:0] SHROTOP_SRL = 4'd1;
    localparam logic [ALUOP2_W-1:0] SHROTOP_SRA = 4'd2;
    localparam logic [ALUOP2_W-1:0] SHROTOP_ROR = 4'd3;

    localparam logic [2:0] COMPOP_EQ = 3'd0;
    localparam logic [2:0] COMPOP_NE = 3'd1;
    localparam logic [2:0] COMPOP_GT = 3'd2;
    localparam logic [2:0] COMPOP_GE = 3'd3;
    localparam logic [2:0] COMPOP_LT = 3'd4;
    localparam logic [2:0] COMPOP_LE = 3'd5;

    localparam int unsigned CUST5_START = 0;
    localparam int unsigned CUST5_WRITE = 1;
    localparam int unsigned CUST5_LAST  = 2;
    localparam int unsigned CUST5_READ  = 3;
    localparam int unsigned CUST5_STOP  = 4;

    // Field order matches the CUST5 read-back layout (keccak_en in bit 0).
    typedef struct packed {
        logic hash_num;
        logic is_last;
        logic out32;
        logic in_ready;
        logic keccak_en;
    } keccak_state_t;

endpackage

// File: rtl/or1200_keccak_ctrl.sv
// Registered Keccak command decoder driven by one-hot l.cust5 sub-ops.
module or1200_keccak_ctrl
    import or1200_keccak_alu_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CUST5_OP_W-1:0]   cust5_op,
    input  logic [CUST5_LIMM_W-1:0] cust5_limm,
    output keccak_state_t           state
);

    keccak_state_t state_q, state_d;
    logic          unused_limm;

    assign unused_limm = ^cust5_limm[CUST5_LIMM_W-1:1];

    always_comb begin
        state_d          = state_q;
        // Strobes live for exactly one cycle per sampled command.
        state_d.in_ready = 1'b0;
        state_d.out32    = 1'b0;
        if (cust5_op[CUST5_STOP]) begin
            state_d = '0;
        end else if (cust5_op[CUST5_START]) begin
            state_d.keccak_en = 1'b1;
            state_d.hash_num  = cust5_limm[0];
            state_d.is_last   = 1'b0;
        end else if (state_q.keccak_en) begin
            if (cust5_op[CUST5_WRITE]) state_d.in_ready = 1'b1;
            if (cust5_op[CUST5_LAST])  state_d.is_last  = 1'b1;
            if (cust5_op[CUST5_READ])  state_d.out32    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/or1200_keccak_alu.sv
// OR1200 execute-stage ALU with Keccak coprocessor control outputs.
// Optional rotate support: define OR1200_IMPL_ALU_ROTATE_EN.
module or1200_keccak_alu
    import or1200_keccak_alu_pkg::*;
#(
    parameter int unsigned WIDTH        = ALU_WIDTH,
    parameter int unsigned ALUOP_WIDTH  = ALUOP_W,
    parameter int unsigned ALUOP2_WIDTH = ALUOP2_W,
    parameter int unsigned COMPOP_WIDTH = COMPOP_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic [WIDTH-1:0]        mult_mac_result,
    input  logic                    macrc_op,
    input  logic [ALUOP_WIDTH-1:0]  alu_op,
    input  logic [ALUOP2_WIDTH-1:0] alu_op2,
    input  logic [COMPOP_WIDTH-1:0] comp_op,
    input  logic [4:0]              cust5_op,
    input  logic [5:0]              cust5_limm,
    output logic [WIDTH-1:0]        result,
    output logic                    flagforw,
    output logic                    flag_we,
    output logic                    ovforw,
    output logic                    ov_we,
    output logic                    cyforw,
    output logic                    cy_we,
    input  logic                    carry,
    input  logic                    flag,
    output logic                    keccak_en,
    output logic                    out32,
    output logic                    in_ready,
    output logic                    is_last,
    output logic                    hash_num
);

    keccak_state_t kstate;

    or1200_keccak_ctrl u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .cust5_op   (cust5_op),
        .cust5_limm (cust5_limm),
        .state      (kstate)
    );

    assign keccak_en = kstate.keccak_en;
    assign out32     = kstate.out32;
    assign in_ready  = kstate.in_ready;
    assign is_last   = kstate.is_last;
    assign hash_num  = kstate.hash_num;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic               sum_ov, diff_ov, borrow;
    logic [4:0]         shamt;
    logic [WIDTH-1:0]   shrot;
    logic [2*WIDTH-1:0] ror_dbl;
    logic [WIDTH-1:0]   ff1, fl1;
    logic               cmp_eq, cmp_lt, cmp_flag;

    assign sum     = {1'b0, a} + {1'b0, b} +
                     {{WIDTH{1'b0}}, (alu_op == ALUOP_ADDC) & carry};
    assign sum_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign diff    = a - b;
    assign borrow  = a < b;
    assign diff_ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    assign shamt   = b[4:0];
    assign ror_dbl = {a, a} >> shamt;

    always_comb begin
        shrot = '0;
        case (alu_op2)
            SHROTOP_SLL: shrot = a << shamt;
            SHROTOP_SRL: shrot = a >> shamt;
            SHROTOP_SRA: shrot = $signed(a) >>> shamt;
`ifdef OR1200_IMPL_ALU_ROTATE_EN
            SHROTOP_ROR: shrot = ror_dbl[WIDTH-1:0];
`endif
            default:     shrot = '0;
        endcase
    end

    // Lowest set bit wins for ff1 (scan downward), highest for fl1 (scan upward).
    always_comb begin
        ff1 = '0;
        fl1 = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (a[i]) ff1 = WIDTH'(i + 1);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) fl1 = WIDTH'(i + 1);
        end
    end

    assign cmp_eq = (a == b);
    assign cmp_lt = comp_op[3] ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        cmp_flag = 1'b0;
        case (comp_op[2:0])
            COMPOP_EQ: cmp_flag = cmp_eq;
            COMPOP_NE: cmp_flag = !cmp_eq;
            COMPOP_GT: cmp_flag = !cmp_lt && !cmp_eq;
            COMPOP_GE: cmp_flag = !cmp_lt;
            COMPOP_LT: cmp_flag = cmp_lt;
            COMPOP_LE: cmp_flag = cmp_lt || cmp_eq;
            default:   cmp_flag = 1'b0;
        endcase
    end

    always_comb begin
        result   = '0;
        flagforw = 1'b0;
        flag_we  = 1'b0;
        ovforw   = 1'b0;
        ov_we    = 1'b0;
        cyforw   = 1'b0;
        cy_we    = 1'b0;
        case (alu_op)
            ALUOP_ADD, ALUOP_ADDC: begin
                result = sum[WIDTH-1:0];
                cyforw = sum[WIDTH];
                ovforw = sum_ov;
                cy_we  = 1'b1;
                ov_we  = 1'b1;
            end
            ALUOP_SUB: begin
                result = diff;
                cyforw = borrow;
                ovforw = diff_ov;
                cy_we  = 1'b1;
                ov_we  = 1'b1;
            end
            ALUOP_AND:   result = a & b;
            ALUOP_OR:    result = a | b;
            ALUOP_XOR:   result = a ^ b;
            ALUOP_MUL, ALUOP_DIV, ALUOP_DIVU, ALUOP_MULU: result = mult_mac_result;
            ALUOP_SHROT: result = shrot;
            ALUOP_CUST5: result = {{(WIDTH - 5){1'b0}}, kstate};
            ALUOP_CMOV:  result = flag ? a : b;
            ALUOP_FFL1:  result = alu_op2[0] ? fl1 : ff1;
            ALUOP_MOVHI: result = {b[15:0], {(WIDTH - 16){1'b0}}};
            ALUOP_COMP: begin
                flagforw = cmp_flag;
                flag_we  = 1'b1;
            end
            default:     result = '0;
        endcase
        if (macrc_op) result = mult_mac_result;
    end

endmodule

// File: tb/tb_or1200_keccak_alu.sv
// Directed bench: table of ALU vectors plus hand-written Keccak command sequences.
module tb_or1200_keccak_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b, mult_mac_result;
    logic        macrc_op;
    logic [4:0]  alu_op;
    logic [3:0]  alu_op2, comp_op;
    logic [4:0]  cust5_op;
    logic [5:0]  cust5_limm;
    logic [31:0] result;
    logic        flagforw, flag_we, ovforw, ov_we, cyforw, cy_we;
    logic        carry, flag;
    logic        keccak_en, out32, in_ready, is_last, hash_num;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    or1200_keccak_alu dut (
        .clk             (clk),
        .reset           (reset),
        .a               (a),
        .b               (b),
        .mult_mac_result (mult_mac_result),
        .macrc_op        (macrc_op),
        .alu_op          (alu_op),
        .alu_op2         (alu_op2),
        .comp_op         (comp_op),
        .cust5_op        (cust5_op),
        .cust5_limm      (cust5_limm),
        .result          (result),
        .flagforw        (flagforw),
        .flag_we         (flag_we),
        .ovforw          (ovforw),
        .ov_we           (ov_we),
        .cyforw          (cyforw),
        .cy_we           (cy_we),
        .carry           (carry),
        .flag            (flag),
        .keccak_en       (keccak_en),
        .out32           (out32),
        .in_ready        (in_ready),
        .is_last         (is_last),
        .hash_num        (hash_num)
    );

    // st = {flag_we, flagforw, cy_we, cyforw, ov_we, ovforw}
    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [3:0]  op2;
        logic [3:0]  cmp;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] mac;
        logic        cin;
        logic        flg;
        logic        macrc;
        logic        chk_res;
        logic [31:0] exp_res;
        logic [5:0]  exp_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [4:0] op, logic [3:0] op2, logic [3:0] cmp,
                                logic [31:0] va, logic [31:0] vb, logic [31:0] mac,
                                logic cin, logic flg, logic macrc, logic chk_res,
                                logic [31:0] exp_res, logic [5:0] exp_st);
        vec_t v;
        v.name = name; v.op = op; v.op2 = op2; v.cmp = cmp; v.a = va; v.b = vb;
        v.mac = mac; v.cin = cin; v.flg = flg; v.macrc = macrc; v.chk_res = chk_res;
        v.exp_res = exp_res; v.exp_st = exp_st;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // k = {hash_num, is_last, out32, in_ready, keccak_en}
    task automatic check_k(string name, logic [4:0] exp);
        check(name, {27'b0, hash_num, is_last, out32, in_ready, keccak_en}, {27'b0, exp});
    endtask

    task automatic step(logic [4:0] op, logic [5:0] limm);
        cust5_op   = op;
        cust5_limm = limm;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ror_exp;

    initial begin
        reset = 1'b0; a = '0; b = '0; mult_mac_result = '0; macrc_op = 1'b0;
        alu_op = 5'd7; alu_op2 = '0; comp_op = '0; cust5_op = '0; cust5_limm = '0;
        carry = 1'b0; flag = 1'b0;

`ifdef OR1200_IMPL_ALU_ROTATE_EN
        ror_exp = 32'h8000_0000;
`else
        ror_exp = 32'h0;
`endif

        vecs.push_back(mk("add_carry", 0, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0, 1, 32'h0, 6'b001110));
        vecs.push_back(mk("add_ovf", 0, 0, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 0, 1, 32'h80000000, 6'b001011));
        vecs.push_back(mk("add_nocin", 0, 0, 0, 32'h1, 32'h1, 0, 1, 0, 0, 1, 32'h2, 6'b001010));
        vecs.push_back(mk("addc", 1, 0, 0, 32'h1, 32'h1, 0, 1, 0, 0, 1, 32'h3, 6'b001010));
        vecs.push_back(mk("sub_borrow", 2, 0, 0, 32'h1, 32'h2, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 6'b001110));
        vecs.push_back(mk("sub_ovf", 2, 0, 0, 32'h80000000, 32'h1, 0, 0, 0, 0, 1, 32'h7FFFFFFF, 6'b001011));
        vecs.push_back(mk("and", 3, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 0, 1, 32'hF000F000, 6'b0));
        vecs.push_back(mk("or", 4, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 0, 1, 32'hFFF0FFF0, 6'b0));
        vecs.push_back(mk("xor", 5, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 0, 1, 32'h0FF00FF0, 6'b0));
        vecs.push_back(mk("mul", 6, 0, 0, 32'h3, 32'h4, 32'h12345678, 0, 0, 0, 1, 32'h12345678, 6'b0));
        vecs.push_back(mk("divu", 10, 0, 0, 32'h3, 32'h4, 32'hCAFEF00D, 0, 0, 0, 1, 32'hCAFEF00D, 6'b0));
        vecs.push_back(mk("macrc", 0, 0, 0, 32'h1, 32'h1, 32'hA5A5A5A5, 0, 0, 1, 1, 32'hA5A5A5A5, 6'b001010));
        vecs.push_back(mk("sll", 8, 0, 0, 32'h1, 32'd31, 0, 0, 0, 0, 1, 32'h80000000, 6'b0));
        vecs.push_back(mk("srl", 8, 1, 0, 32'h80000000, 32'd4, 0, 0, 0, 0, 1, 32'h08000000, 6'b0));
        vecs.push_back(mk("sra", 8, 2, 0, 32'h80000000, 32'd4, 0, 0, 0, 0, 1, 32'hF8000000, 6'b0));
        vecs.push_back(mk("sra_b_mask", 8, 2, 0, 32'h80000000, 32'h24, 0, 0, 0, 0, 1, 32'hF8000000, 6'b0));
        vecs.push_back(mk("ror", 8, 3, 0, 32'h1, 32'h1, 0, 0, 0, 0, 1, ror_exp, 6'b0));
        vecs.push_back(mk("movhi", 16, 0, 0, 32'h0, 32'h1234ABCD, 0, 0, 0, 0, 1, 32'hABCD0000, 6'b0));
        vecs.push_back(mk("cmov_f1", 14, 0, 0, 32'h11, 32'h22, 0, 0, 1, 0, 1, 32'h11, 6'b0));
        vecs.push_back(mk("cmov_f0", 14, 0, 0, 32'h11, 32'h22, 0, 0, 0, 0, 1, 32'h22, 6'b0));
        vecs.push_back(mk("ff1", 15, 0, 0, 32'h100, 0, 0, 0, 0, 0, 1, 32'd9, 6'b0));
        vecs.push_back(mk("fl1", 15, 1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 32'd9, 6'b0));
        vecs.push_back(mk("ff1_two", 15, 0, 0, 32'h80000001, 0, 0, 0, 0, 0, 1, 32'd1, 6'b0));
        vecs.push_back(mk("fl1_two", 15, 1, 0, 32'h80000001, 0, 0, 0, 0, 0, 1, 32'd32, 6'b0));
        vecs.push_back(mk("ff1_zero", 15, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'd0, 6'b0));
        vecs.push_back(mk("lts", 17, 0, 4'hC, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0, 0, 0, 6'b110000));
        vecs.push_back(mk("ltu", 17, 0, 4'h4, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0, 0, 0, 6'b100000));
        vecs.push_back(mk("eq", 17, 0, 4'h0, 32'h5, 32'h5, 0, 0, 0, 0, 0, 0, 6'b110000));
        vecs.push_back(mk("ne", 17, 0, 4'h1, 32'h5, 32'h5, 0, 0, 0, 0, 0, 0, 6'b100000));
        vecs.push_back(mk("gts", 17, 0, 4'hA, 32'h1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 6'b110000));
        vecs.push_back(mk("geu", 17, 0, 4'h3, 32'h1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 6'b100000));
        vecs.push_back(mk("les", 17, 0, 4'hD, 32'h5, 32'h5, 0, 0, 0, 0, 0, 0, 6'b110000));
        vecs.push_back(mk("cmp_code6", 17, 0, 4'h6, 32'h5, 32'h5, 0, 0, 0, 0, 0, 0, 6'b100000));
        vecs.push_back(mk("bad_op", 7, 0, 0, 32'h5, 32'h5, 32'h77, 0, 0, 0, 1, 32'h0, 6'b0));

        // Keccak control: reset, ignored commands, start/hold/read/write/last/stop.
        step(5'b00001, 6'd1);
        step(5'b00001, 6'd1);
        check_k("reset_dominates", 5'b00000);
        reset = 1'b1;
        step(5'b00000, 6'd0);
        check_k("idle", 5'b00000);
        step(5'b00100, 6'd1);
        check_k("last_ignored", 5'b00000);
        step(5'b00010, 6'd1);
        check_k("write_ignored", 5'b00000);
        step(5'b00001, 6'd1);
        check_k("start", 5'b10001);
        alu_op = 5'd12;
        #1;
        check("cust5_result", result, 32'h11);
        for (int i = 0; i < 10; i++) begin
            step(5'b00001, 6'd1);
            check_k("start_hold", 5'b10001);
        end
        step(5'b01000, 6'd1);
        check_k("read1", 5'b10101);
        step(5'b01000, 6'd1);
        check_k("read2", 5'b10101);
        step(5'b00000, 6'd1);
        check_k("read_clear", 5'b10001);
        step(5'b00010, 6'd1);
        check_k("write", 5'b10011);
        step(5'b00000, 6'd1);
        check_k("write_clear", 5'b10001);
        step(5'b00100, 6'd1);
        check_k("last", 5'b11001);
        step(5'b00000, 6'd1);
        check_k("last_sticky", 5'b11001);
        step(5'b01000, 6'd1);
        check_k("last_read", 5'b11101);
        step(5'b00001, 6'd0);
        check_k("restart", 5'b00001);
        step(5'b10001, 6'd1);
        check_k("stop_over_start", 5'b00000);
        step(5'b00011, 6'd1);
        check_k("start_over_write", 5'b10001);
        step(5'b11110, 6'd1);
        check_k("stop", 5'b00000);
        step(5'b00000, 6'd0);

        // Combinational ALU vectors with Keccak idle.
        foreach (vecs[i]) begin
            vec_t v;
            logic [5:0] st, mask;
            v = vecs[i];
            alu_op = v.op; alu_op2 = v.op2; comp_op = v.cmp; a = v.a; b = v.b;
            mult_mac_result = v.mac; carry = v.cin; flag = v.flg; macrc_op = v.macrc;
            @(negedge clk);
            mask = {1'b1, v.exp_st[5], 1'b1, v.exp_st[3], 1'b1, v.exp_st[1]};
            st   = {flag_we, flagforw, cy_we, cyforw, ov_we, ovforw} & mask;
            if (v.chk_res) check({v.name, "_res"}, result, v.exp_res);
            check({v.name, "_st"}, {26'b0, st}, {26'b0, v.exp_st});
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/or1200_keccak_alu.md
Name: or1200_keccak_alu

Overview:
OR1200 integer ALU for the execute stage, extended with a Keccak hash-coprocessor control interface.
- Arithmetic, logic, shift, compare, cmov and find-first/last-one results are combinational, as in the stock OR1200 pipeline.
- Keccak control outputs come from a small registered state machine. It is driven by custom instructions (l.cust5 sub-ops) and feeds the Keccak core.

Parameters:
- WIDTH, 32, operand/result width.
- ALUOP_WIDTH, 5, alu_op width.
- ALUOP2_WIDTH, 4, alu_op2 width.
- COMPOP_WIDTH, 4, comp_op width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- mult_mac_result  in  WIDTH  multiplier/MAC result.
- macrc_op  in  1  l.macrc: forces result to mult_mac_result.
- alu_op  in  5  ALU operation.
- alu_op2  in  4  sub-operation (shift type, ff1/fl1).
- comp_op  in  4  compare type; bit3 = signed.
- cust5_op  in  5  Keccak command, one-hot.
- cust5_limm  in  6  command immediate.
- result  out  WIDTH  ALU result.
- flagforw  out  1  compare flag.
- flag_we  out  1  flag write enable.
- ovforw  out  1  overflow.
- ov_we  out  1  overflow write enable.
- cyforw  out  1  carry.
- cy_we  out  1  carry write enable.
- carry  in  1  SR[CY].
- flag  in  1  SR[F], used by cmov.
- keccak_en  out  1  core enable.
- out32  out  1  read-word strobe.
- in_ready  out  1  input-word-valid strobe.
- is_last  out  1  last input block.
- hash_num  out  1  hash variant select.

Behaviour:
- alu_op encodings:
  - 0 ADD, 1 ADDC, 2 SUB, 3 AND, 4 OR, 5 XOR.
  - 6 MUL, 9 DIV, 10 DIVU, 11 MULU: result = mult_mac_result.
  - 8 SHROT, 12 CUST5, 14 CMOV, 15 FFL1, 16 MOVHI, 17 COMP.
  - Any other code: result = 0, all write enables 0.
- macrc_op=1 overrides the result with mult_mac_result.
- ADD/ADDC: WIDTH+1-bit sum a+b(+carry).
  - cyforw = bit WIDTH; cy_we=1.
  - ovforw = signed overflow; ov_we=1.
- SUB: a-b; cyforw = borrow (a<b unsigned); ov per signed rule; cy_we=ov_we=1.
- SHROT: shift amount is b[4:0]; alu_op2 0 SLL, 1 SRL, 2 SRA, 3 ROR.
- MOVHI: result = {b[15:0],16'h0}.
- CMOV: result = flag ? a : b.
- FFL1: result is the 1-based index of the lowest (alu_op2[0]=0) or highest (alu_op2[0]=1) set bit of a; 0 if a==0.
- COMP: comp_op[2:0] 0 EQ, 1 NE, 2 GT, 3 GE, 4 LT, 5 LE; comp_op[3]=1 signed. flagforw = outcome; flag_we=1. Codes 6/7 give flagforw=0.
- CUST5 result = {27'b0, hash_num, is_last, out32, in_ready, keccak_en} (current register values).
- Keccak commands:
  - Decoded from cust5_op on every rising clk edge, independent of alu_op; the decoder drives cust5_op=0 for non-custom instructions.
  - Priority when several bits are set: bit4 > bit0 > others.
  - STOP (bit4): clear all five outputs.
  - START (bit0): keccak_en<=1, hash_num<=cust5_limm[0], is_last<=0. Repeating START while enabled re-applies the same values.
  - WRITE (bit1): in_ready=1 for the next cycle only.
  - LAST (bit2): is_last<=1, sticky until START/STOP.
  - READ (bit3): out32=1 for the next cycle only.
- in_ready and out32 are 0 on every cycle whose sampled command lacks bit1/bit3. A held command re-pulses them each cycle.
- WRITE, LAST and READ are ignored while keccak_en=0.
- Reset (reset=0 at clk edge): all five Keccak outputs = 0; reset dominates any command. Combinational outputs are unaffected by reset.

Optional Feature:
OR1200_IMPL_ALU_ROTATE_EN.
- Defined: SHROT with alu_op2=3 performs rotate right by b[4:0].
- Undefined: rotate hardware is omitted and alu_op2=3 yields result 0.

Decomposition:
- Package or1200_keccak_alu_pkg holds:
  - ALUOP, SHROTOP, COMPOP and CUST5 command localparams;
  - width constants;
  - the Keccak state struct.
- One sub-module, or1200_keccak_ctrl, holds the registered command decoder; the ALU datapath stays in the top.

Test Plan:
- Reset low for 2 cycles, then cust5_op=0 -> keccak_en=out32=in_ready=is_last=hash_num=0.
- From idle, cust5_limm=1; cust5_op=00100, then 00010 -> ignored, all outputs stay 0.
- cust5_op=00001 with limm=1 -> next edge keccak_en=1, hash_num=1, is_last=0.
- Hold START 10 cycles -> outputs unchanged. Then cust5_op=01000 -> out32=1 each cycle while held. Then cust5_op=0 -> out32=0 on the next cycle. Then LAST -> is_last=1 sticky. Then STOP -> all 0.
- ADD a=FFFFFFFF, b=1 -> result 0, cyforw=1, ovforw=0. ADD a=7FFFFFFF, b=1 -> ovforw=1. SUB a=1, b=2 -> result FFFFFFFF, cyforw=1.
- COMP signed LT a=FFFFFFFF, b=1 -> flagforw=1; unsigned LT -> 0. SRA a=80000000 by 4 -> F8000000. FFL1 a=00000100: FF1 -> 9, FL1 -> 9.
